// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider: one quotient bit per clock and DVD_W cycles per divide.
// A zero divisor produces an immediate all-ones quotient and raises div_by_zero.
module shift_sub_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [DVD_W-1:0] r_dvd;
  logic [DVS_W-1:0] r_dvs;
  logic [DVS_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_quot;
  logic [DVS_W-1:0] r_remout;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;

  logic [DVS_W:0]   w_t;
  logic [DVS_W:0]   w_sub;
  logic             w_qbit;
  logic [DVS_W-1:0] w_rem_nxt;
  logic [DVD_W-1:0] w_dvd_nxt;
  logic             w_last;

  // The partial remainder stays below the divisor, so t < 2*divisor and the
  // sign bit of t - divisor is exactly the borrow; the stored remainder
  // therefore never needs its top bit.
  always_comb begin
    w_t       = {r_rem, r_dvd[DVD_W-1]};
    w_sub     = w_t - {1'b0, r_dvs};
    w_qbit    = ~w_sub[DVS_W];
    w_rem_nxt = w_qbit ? w_sub[DVS_W-1:0] : w_t[DVS_W-1:0];
    w_dvd_nxt = {r_dvd[DVD_W-2:0], w_qbit};
    w_last    = (r_cnt == CNT_W'(DVD_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remout <= '0;
      r_dbz    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quot   <= '1;
              r_remout <= '0;
              r_dbz    <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_dvd   <= dividend;
              r_dvs   <= divisor;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_dvd <= w_dvd_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_quot   <= w_dvd_nxt;
            r_remout <= w_rem_nxt;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remout;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider: vector table plus abort, reset and
// back-to-back sequences, all against hand-computed results.
module tb_shift_sub_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    int         busy_n;
  } vec_t;

  vec_t vecs[5];

  shift_sub_divider #(.DVD_W(8), .DVS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges are counted from the one that samples start (that edge is 1).
  task automatic wait_done(input bit drop_start, output int n, output bit seen, output int busy_n);
    n = 0; seen = 1'b0; busy_n = 0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (drop_start) start = 1'b0;
      if (busy) busy_n++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int  n, bn;
    bit  seen;
    @(negedge clk);
    dividend = v.dvd; divisor = v.dvs; start = 1'b1;
    wait_done(1'b1, n, seen, bn);
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, 32'(n), 32'(v.lat));
    chk({name, " busy_cycles"}, 32'(bn), 32'(v.busy_n));
    chk({name, " quotient"}, 32'(quotient), 32'(v.q));
    chk({name, " remainder"}, 32'(remainder), 32'(v.r));
    chk({name, " dbz"}, 32'(div_by_zero), 32'(v.dbz));
    @(posedge clk); #1;
    chk({name, " done_pulse_end"}, 32'(done), 32'd0);
    chk({name, " quotient_hold"}, 32'(quotient), 32'(v.q));
  endtask

  initial begin
    int  n, bn, cnt;
    bit  seen;

    vecs[0] = '{dvd: 8'd200, dvs: 4'd7,  q: 8'd28,  r: 4'd4, dbz: 1'b0, lat: 9, busy_n: 8};
    vecs[1] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0, dbz: 1'b0, lat: 9, busy_n: 8};
    vecs[2] = '{dvd: 8'd5,   dvs: 4'd9,  q: 8'd0,   r: 4'd5, dbz: 1'b0, lat: 9, busy_n: 8};
    vecs[3] = '{dvd: 8'd0,   dvs: 4'd15, q: 8'd0,   r: 4'd0, dbz: 1'b0, lat: 9, busy_n: 8};
    vecs[4] = '{dvd: 8'd100, dvs: 4'd0,  q: 8'd255, r: 4'd0, dbz: 1'b1, lat: 1, busy_n: 0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start and operand changes in the 3rd CALC cycle must be ignored.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (n == 3) begin start = 1'b1; dividend = 8'd99; divisor = 4'd10; end
      if (n == 4) start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk("ignore done_seen", 32'(seen), 32'd1);
    chk("ignore latency", 32'(n), 32'd9);
    chk("ignore quotient", 32'(quotient), 32'd28);
    chk("ignore remainder", 32'(remainder), 32'd4);
    cnt = 0;
    repeat (6) begin @(posedge clk); #1; if (busy || done) cnt++; end
    chk("ignore no_second_op", 32'(cnt), 32'd0);

    // Reset in the 4th CALC cycle aborts with no done pulse.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    repeat (4) begin @(posedge clk); #1; start = 1'b0; end
    chk("abort busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort quotient", 32'(quotient), 32'd0);
    chk("abort remainder", 32'(remainder), 32'd0);
    chk("abort dbz", 32'(div_by_zero), 32'd0);
    cnt = 0;
    repeat (3) begin @(posedge clk); #1; if (done || busy) cnt++; end
    chk("abort held", 32'(cnt), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op('{dvd: 8'd77, dvs: 4'd3, q: 8'd25, r: 4'd2, dbz: 1'b0, lat: 9, busy_n: 8}, "post_reset");

    // Back-to-back with start held high throughout.
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    wait_done(1'b0, n, seen, bn);
    chk("b2b first_latency", 32'(n), 32'd9);
    chk("b2b first_quotient", 32'(quotient), 32'd28);
    chk("b2b first_remainder", 32'(remainder), 32'd4);
    dividend = 8'd99; divisor = 4'd10;
    wait_done(1'b0, n, seen, bn);
    start = 1'b0;
    chk("b2b second_seen", 32'(seen), 32'd1);
    chk("b2b spacing", 32'(n), 32'd10);
    chk("b2b second_quotient", 32'(quotient), 32'd9);
    chk("b2b second_remainder", 32'(remainder), 32'd9);
    chk("b2b second_dbz", 32'(div_by_zero), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
